// File: rtl/and4_tree_pipe_if.sv
// ---------------------------------------------------------------------------
// and4_tree_pipe_if
//   Bundles the transaction-side signals of and4_tree_pipe.
//
//   Handshake: a transaction is accepted on a rising clk edge where
//   in_valid=1 and stall=0. stall=1 freezes the whole pipeline: nothing is
//   accepted, nothing advances, and out_valid/y keep their values. A result
//   is new on an edge-to-edge window where out_valid=1 and stall=0. There is
//   no ready; the source must hold its inputs while stall=1.
//
//   Ports (master = source/consumer side, slave = the pipeline):
//     in_valid  : input transaction present
//     stall     : freezes every pipeline register
//     mode      : 0 = AND, 1 = NAND, travels with its transaction
//     a         : LANES*WIDTH bits, lane k at [k*WIDTH +: WIDTH]
//     out_valid : y holds a new result
//     y         : LANES bits, one reduction result per lane
// ---------------------------------------------------------------------------
interface and4_tree_pipe_if #(
    parameter int WIDTH = 16,
    parameter int LANES = 2
);
    logic                   in_valid;
    logic                   stall;
    logic                   mode;
    logic [LANES*WIDTH-1:0] a;
    logic                   out_valid;
    logic [LANES-1:0]       y;

    modport master (
        output in_valid, stall, mode, a,
        input  out_valid, y
    );

    modport slave (
        input  in_valid, stall, mode, a,
        output out_valid, y
    );
endinterface

// File: rtl/and4_tree_pipe.sv
// ---------------------------------------------------------------------------
// and4_tree_pipe
//   Pipelined multi-lane AND/NAND reduction. Each lane reduces WIDTH bits to
//   one bit through a tree of 4-input AND groups with one register level per
//   tree level (L = ceil(log4(WIDTH)), minimum 1). Valid and mode bits ride
//   alongside the data; the last level applies y = AND XOR mode.
//
//   Parameters:
//     WIDTH : bits per lane, 2..256
//     LANES : independent lanes, 1..8
//   Ports:
//     clk   : rising-edge clock
//     rst   : synchronous active-high reset, wins over stall
//     bus   : and4_tree_pipe_if.slave (in_valid, stall, mode, a, out_valid, y)
//
//   Build option:
//     AND4_TREE_OUT_REG_EN defined   : extra output register after the
//                                      inversion, latency L+1
//     AND4_TREE_OUT_REG_EN undefined : y comes from the level-L registers
//                                      through the inversion, latency L
// ---------------------------------------------------------------------------
module and4_tree_pipe #(
    parameter int WIDTH = 16,
    parameter int LANES = 2
) (
    input logic              clk,
    input logic              rst,
    and4_tree_pipe_if.slave  bus
);

    // Number of live bits per lane after 'lvl' tree levels.
    function automatic int level_bits(input int lvl);
        int n;
        n = WIDTH;
        for (int i = 0; i < lvl; i++) begin
            n = (n + 3) / 4;
        end
        return n;
    endfunction

    function automatic int tree_depth();
        int n;
        int d;
        n = WIDTH;
        d = 0;
        while (n > 1) begin
            n = (n + 3) / 4;
            d++;
        end
        if (d < 1) begin
            d = 1;
        end
        return d;
    endfunction

    localparam int L = tree_depth();

    for (genvar j = 1; j <= L; j++) begin : lvl
        localparam int NIN  = level_bits(j - 1);
        localparam int NOUT = level_bits(j);

        logic [LANES*NIN-1:0]  din;
        logic                  v_in;
        logic                  m_in;
        logic [LANES*NOUT-1:0] dnext;
        logic [LANES*NOUT-1:0] dq;
        logic                  vq;
        logic                  mq;

        if (j == 1) begin : src
            assign din  = bus.a;
            assign v_in = bus.in_valid;
            assign m_in = bus.mode;
        end else begin : src
            assign din  = lvl[j-1].dq;
            assign v_in = lvl[j-1].vq;
            assign m_in = lvl[j-1].mq;
        end

        // Each group is kept as an explicit 4-input AND so the swappable
        // AND4 inputs stay visible; a short last group is padded with 1s.
        for (genvar k = 0; k < LANES; k++) begin : lane
            for (genvar g = 0; g < NOUT; g++) begin : grp
                logic [3:0] quad;
                for (genvar b = 0; b < 4; b++) begin : pin
                    if (4 * g + b < NIN) begin : live
                        assign quad[b] = din[k*NIN + 4*g + b];
                    end else begin : pad
                        assign quad[b] = 1'b1;
                    end
                end
                assign dnext[k*NOUT + g] = &quad;
            end
        end

        // Valid advances on every non-stalled edge so bubbles propagate;
        // data and mode only load with a valid transaction so the last
        // result is held across bubbles.
        always_ff @(posedge clk) begin
            if (rst) begin
                vq <= 1'b0;
                mq <= 1'b0;
                dq <= '0;
            end else if (!bus.stall) begin
                vq <= v_in;
                if (v_in) begin
                    dq <= dnext;
                    mq <= m_in;
                end
            end
        end
    end

    logic [LANES-1:0] tree_y;
    assign tree_y = lvl[L].dq ^ {LANES{lvl[L].mq}};

`ifdef AND4_TREE_OUT_REG_EN
    logic [LANES-1:0] y_q;
    logic             ov_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q  <= '0;
            ov_q <= 1'b0;
        end else if (!bus.stall) begin
            ov_q <= lvl[L].vq;
            if (lvl[L].vq) begin
                y_q <= tree_y;
            end
        end
    end

    assign bus.y         = y_q;
    assign bus.out_valid = ov_q;
`else
    assign bus.y         = tree_y;
    assign bus.out_valid = lvl[L].vq;
`endif

endmodule
